// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and constants for the buffered 8N1 UART transmitter.
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int DATA_W     = 8;
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_fifo_fifo.sv
// Byte FIFO with wrapping pointers, occupancy, and dropped-write pulse.
module sync_fifo_byte
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [DEPTH_LOG2:0] level,
  output logic              overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2:0] rptr_q, rptr_d;
  logic ovf_q, ovf_d;
  logic push, pop;

  assign full = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);
  assign empty    = (wptr_q == rptr_q);
  assign level    = wptr_q - rptr_q;
  assign overflow = ovf_q;
  assign rd_data  = mem_q[rptr_q[DEPTH_LOG2-1:0]];

  // full is sampled before the edge, so a same-cycle pop never frees a slot
  assign push = wr_en & ~full;
  assign pop  = rd_en & ~empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = wr_en & full;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[DEPTH_LOG2-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter draining a byte FIFO LSB-first, back-to-back.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int BAUD_DIV   = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] datain,
  input  logic              wrsig,
  output logic              full,
  output logic              empty,
  output logic [DEPTH_LOG2:0] level,
  output logic              overflow,
  output logic              busy,
  output logic              tx
);

  localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);

  tx_state_e         state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic [DATA_W-1:0] head;
  logic              pop;
  logic              last;

  sync_fifo_byte #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .wr_en    (wrsig),
    .wr_data  (datain),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  assign last = (cnt_q == LAST);
  assign busy = (state_q != IDLE) | ~empty;
  assign tx   = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (last) begin
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (last) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (last) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule
